// File: rtl/shift_add_mult8.sv
// shift_add_mult8: sequential 8x8 unsigned shift-and-add multiplier.
// A single adder8 instance is time-shared across eight iterations to build a
// 16-bit product. Acceptance to done takes 8 cycles; one result per 10 cycles.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-high reset
//   start    in   1   multiply request, sampled only while idle
//   a        in   8   multiplicand, captured on acceptance
//   b        in   8   multiplier, captured on acceptance
//   busy     out  1   high while iterating
//   done     out  1   one-cycle pulse when product has just updated
//   product  out 16   registered result, held until the next done
//
// adder8: 8-bit ripple-carry adder; overflow is the carry out of bit 7.
//   a, b      in   8  addends
//   sum       out  8  low 8 bits of a + b
//   overflow  out  1  carry out

module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       overflow
);

  always_comb begin
    logic carry;
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    overflow = carry;
  end

endmodule

module shift_add_mult8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      r_state,   w_state_d;
  logic [7:0]  r_m,       w_m_d;
  logic [7:0]  r_acc,     w_acc_d;
  logic [7:0]  r_q,       w_q_d;
  logic [2:0]  r_cnt,     w_cnt_d;
  logic [15:0] r_product, w_product_d;

  logic [7:0]  w_add_sum;
  logic        w_add_carry;
  logic [7:0]  w_s;
  logic        w_c;

  adder8 u_adder8 (
    .a        (r_acc),
    .b        (r_m),
    .sum      (w_add_sum),
    .overflow (w_add_carry)
  );

  // Add M only when the current multiplier bit is set; otherwise pass Acc.
  assign w_s = r_q[0] ? w_add_sum : r_acc;
  assign w_c = r_q[0] & w_add_carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_m       <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      r_state   <= w_state_d;
      r_m       <= w_m_d;
      r_acc     <= w_acc_d;
      r_q       <= w_q_d;
      r_cnt     <= w_cnt_d;
      r_product <= w_product_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_m_d       = r_m;
    w_acc_d     = r_acc;
    w_q_d       = r_q;
    w_cnt_d     = r_cnt;
    w_product_d = r_product;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_m_d     = a;
          w_q_d     = b;
          w_acc_d   = '0;
          w_cnt_d   = '0;
          w_state_d = StRun;
        end
      end
      StRun: begin
        // {C,S} shifted right one place across Acc:Q.
        w_acc_d = {w_c, w_s[7:1]};
        w_q_d   = {w_s[0], r_q[7:1]};
        w_cnt_d = r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          w_product_d = {w_c, w_s[7:1], w_s[0], r_q[7:1]};
          w_state_d   = StDone;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign busy    = (r_state == StRun);
  assign done    = (r_state == StDone);
  assign product = r_product;

endmodule

// File: tb/tb_shift_add_mult8.sv
// tb_shift_add_mult8: directed and random checks of shift_add_mult8.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_shift_add_mult8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_tests = 0;
  int n_fail  = 0;

  shift_add_mult8 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Drive one multiply from IDLE/DONE and wait for done (bounded).
  // Operands are scrambled right after acceptance.
  task automatic run_mult(input logic [7:0] ia, input logic [7:0] ib,
                          output logic [15:0] p, output int lat, output int nbusy,
                          output bit overlap, output bit timeout);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    lat = 0; nbusy = 0; overlap = 1'b0; timeout = 1'b0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (!done) timeout = 1'b1;
    if (busy && done) overlap = 1'b1;
    p = product;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++;
    if (product !== 16'h0000) begin
      n_fail++; $display("FAIL reset_product: got %h want 0000", product);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] p; int lat, nbusy; bit ov, to;
    run_mult(8'h0D, 8'h0B, p, lat, nbusy, ov, to);
    n_tests++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: no done within 20 cycles"); end
    n_tests++;
    if (lat != 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", lat); end
    n_tests++;
    if (nbusy != 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", nbusy); end
    n_tests++;
    if (p !== 16'h008F) begin n_fail++; $display("FAIL basic_product: got %h want 008f", p); end
    n_tests++;
    if (ov !== 1'b0) begin n_fail++; $display("FAIL basic_overlap: busy and done both high"); end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    n_tests++;
    if (product !== 16'h008F) begin
      n_fail++; $display("FAIL basic_product_hold: got %h want 008f", product);
    end
  endtask

  task automatic test_corners();
    logic [7:0]  ta [3];
    logic [7:0]  tb [3];
    logic [15:0] te [3];
    logic [15:0] p; int lat, nbusy; bit ov, to;
    ta[0] = 8'hFF; tb[0] = 8'hFF; te[0] = 16'hFE01;
    ta[1] = 8'h00; tb[1] = 8'hFF; te[1] = 16'h0000;
    ta[2] = 8'h80; tb[2] = 8'h02; te[2] = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      run_mult(ta[i], tb[i], p, lat, nbusy, ov, to);
      n_tests++;
      if (p !== te[i] || to) begin
        n_fail++;
        $display("FAIL corner_%0d: %h*%h got %h want %h (timeout=%0b)",
                 i, ta[i], tb[i], p, te[i], to);
      end
      n_tests++;
      if (lat != 8) begin n_fail++; $display("FAIL corner_%0d_latency: got %0d want 8", i, lat); end
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0; int done_idx = -1; logic [15:0] p = 16'hxxxx;
    @(negedge clk);
    a = 8'h21; b = 8'h07; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h12; b = 8'h34;
    for (int idx = 0; idx < 30; idx++) begin
      if (idx == 2) start = 1'b1;
      else if (idx == 3) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin p = product; done_idx = idx; start = 1'b1; end
      end else if (done_idx >= 0 && idx == done_idx + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_tests++;
    if (ndone != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    n_tests++;
    if (done_idx != 8) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d want 8", done_idx); end
    n_tests++;
    if (p !== 16'h00E7) begin n_fail++; $display("FAIL ignore_product: got %h want 00e7", p); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1; int d2 = -1; logic [15:0] p1 = 16'hxxxx; logic [15:0] p2 = 16'hxxxx;
    bit hold_ok = 1'b1;
    @(negedge clk);
    a = 8'd3; b = 8'd5; start = 1'b1;
    @(negedge clk);
    a = 8'd7; b = 8'd9;
    for (int idx = 0; idx < 26; idx++) begin
      if (done) begin
        if (d1 < 0) begin d1 = idx; p1 = product; end
        else if (d2 < 0) begin d2 = idx; p2 = product; start = 1'b0; end
      end
      if (idx >= 9 && idx <= 17 && product !== 16'h000F) hold_ok = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    n_tests++;
    if (d1 != 8) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 8", d1); end
    n_tests++;
    if (p1 !== 16'h000F) begin n_fail++; $display("FAIL b2b_first_product: got %h want 000f", p1); end
    n_tests++;
    if (d2 != 18) begin n_fail++; $display("FAIL b2b_second_done: got %0d want 18", d2); end
    n_tests++;
    if (p2 !== 16'h003F) begin n_fail++; $display("FAIL b2b_second_product: got %h want 003f", p2); end
    n_tests++;
    if (!hold_ok) begin n_fail++; $display("FAIL b2b_product_hold: got changing value want 000f held"); end
  endtask

  task automatic test_async_reset();
    int ndone = 0; int nbusy = 0;
    logic [15:0] p; int lat, nb; bit ov, to;
    @(negedge clk);
    a = 8'h55; b = 8'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_busy_before: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL arst_done: got %b want 0", done); end
    n_tests++;
    if (product !== 16'h0000) begin n_fail++; $display("FAIL arst_product: got %h want 0000", product); end
    @(negedge clk);
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    n_tests++;
    if (ndone != 0 || nbusy != 0) begin
      n_fail++; $display("FAIL arst_no_done: got done=%0d busy=%0d want 0 0", ndone, nbusy);
    end
    run_mult(8'h02, 8'h03, p, lat, nb, ov, to);
    n_tests++;
    if (p !== 16'h0006 || to) begin
      n_fail++; $display("FAIL arst_fresh: got %h want 0006 (timeout=%0b)", p, to);
    end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb; logic [15:0] p, exp_p; int lat, nbusy; bit ov, to;
    int n_overlap = 0; int n_badlat = 0;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = 8'($urandom); rb = 8'($urandom);
      exp_p = 16'(ra) * 16'(rb);
      run_mult(ra, rb, p, lat, nbusy, ov, to);
      if (ov) n_overlap++;
      if (lat != 8 || nbusy != 8) n_badlat++;
      n_tests++;
      if (p !== exp_p || to) begin
        n_fail++; $display("FAIL rand_%0d: %h*%h got %h want %h", i, ra, rb, p, exp_p);
      end
    end
    n_tests++;
    if (n_overlap != 0) begin n_fail++; $display("FAIL rand_overlap: got %0d want 0", n_overlap); end
    n_tests++;
    if (n_badlat != 0) begin n_fail++; $display("FAIL rand_timing: got %0d bad want 0", n_badlat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_add_mult8.md
# shift_add_mult8

Sequential 8x8 unsigned multiplier controller that time-shares a single `adder8` instance to form a 16-bit product by shift-and-add. The controller holds the operand and partial-product registers and runs an iteration counter and a start/busy/done handshake. It sits between a requesting unit and the existing ripple adder datapath, and is the first clocked consumer of `adder8`. One multiply takes 10 clock cycles from start acceptance to the next possible acceptance.

## Interface
- Parameters: none. Width is fixed at 8 to match `adder8`.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `a`  in  8  multiplicand, unsigned; captured on acceptance.
- `b`  in  8  multiplier, unsigned; captured on acceptance.
- `busy`  out  1  high while iterating (RUN).
- `done`  out  1  one-cycle pulse; product just updated.
- `product`  out  16  registered result; held until the next done.

## Operation
- Internal registers:
  - `M[7:0]`: multiplicand.
  - `Acc[7:0]`: high partial product.
  - `Q[7:0]`: multiplier, low partial product.
  - `cnt[2:0]`: iteration counter.
  - `state`: IDLE, RUN or DONE.
- Exactly one `adder8` instance computes `Acc + M`. Its `overflow` output is the carry bit C. No behavioural `+` or `*` is used on the datapath.
- IDLE:
  - If `start`=1: load `M`<=`a`, `Q`<=`b`, `Acc`<=0, `cnt`<=0, then go to RUN.
  - Otherwise hold all registers.
- RUN, one iteration per cycle:
  - If `Q[0]`=1: `{C,S}` = `adder8(Acc,M)`. Else `{C,S}` = `{0,Acc}`.
  - Shift right: `Acc`<=`{C,S[7:1]}`, `Q`<=`{S[0],Q[7:1]}`.
  - `cnt`<=`cnt`+1.
  - When `cnt`==7, also load `product`<=`{C,S[7:1],S[0],Q[7:1]}` (the post-shift value) and go to DONE.
- DONE: `done`=1 for this single cycle, then go to IDLE unconditionally.
- `start` is ignored in RUN and DONE. It is not queued.
- `a` and `b` may change freely after acceptance without affecting the result.
- Outputs are decoded from registers only (Moore): `busy` = (state==RUN), `done` = (state==DONE).
- Arithmetic: `Acc+M` ≤ 0x1FE, so the carry fits C and the 16-bit product never overflows. 0xFF*0xFF = 0xFE01.
- `cnt` wraps 7->0 implicitly. Its value is don't-care outside RUN.

## Timing
- Reset (async assert, any time): state=IDLE, `busy`=0, `done`=0, `product`=0x0000, and all internal registers 0.
  - Outputs change immediately on assertion, without waiting for a clock edge.
  - Deassertion is synchronised externally. The first edge after deassertion may accept `start`.
- Reset mid-RUN or in DONE aborts the operation. No `done` is produced and `product` reads 0.
- Acceptance at edge E0 (IDLE, `start`=1):
  - `busy` is high from E0 to E8.
  - Iterations occur at E1..E8.
  - `product` updates at E8.
  - `done` is high from E8 to E9.
  - IDLE is re-entered at E9.
  - The earliest next acceptance is E10, with `start` high before E10.
- Latency is 8 cycles from acceptance to `done`. Throughput is one result per 10 cycles.
- Holding `start` continuously gives back-to-back operations every 10 cycles. `a`/`b` are recaptured at each acceptance.
- `product` stays stable between `done` pulses, including during the next RUN.
- `busy` and `done` are never high together.

## Test plan
- Reset, then `a`=0x0D, `b`=0x0B, one-cycle `start` -> `busy` high for 8 cycles, `done` pulses 8 cycles after acceptance, `product`=0x008F.
- `a`=0xFF, `b`=0xFF -> `product`=0xFE01, which exercises the carry path. Also `a`=0x00, `b`=0xFF -> 0x0000, and `a`=0x80, `b`=0x02 -> 0x0100.
- After acceptance, change `a`/`b` to 0x12/0x34 and pulse `start` at E3 and at the DONE cycle -> both pulses are ignored, the result matches the original operands, and exactly one `done` is produced.
- `start` held high with operands (3,5) then (7,9) -> `done` pulses 10 cycles apart with `product` 0x000F then 0x003F. `product` holds 0x000F through the second RUN.
- Assert `rst` between E4 and E5, asynchronously -> `busy`, `done` and `product` go to 0 immediately. No `done` follows. A fresh 0x02*0x03 afterwards gives 0x0006.
- 1000 random (`a`,`b`) pairs with random `start` gaps -> every `product` equals `a`*`b` under the reference model, and `done` and `busy` never overlap.
